// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, transmitter FSM encoding and the
// baud divider calculation used by both the transmit and receive paths.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Clock cycles per oversample tick; truncating division.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    return clk_hz / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word-fall-through read, so the head word is
// available in the same cycle the consumer decides to pop it.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit, so their difference is the fill level.
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: free-running oversample tick generator,
// TX FIFO with valid/ready input, and a frame FSM driving a registered TXD.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_valid,
  input  logic [DATA_BITS-1:0]        i_data,
  output logic                        o_ready,
  output logic                        o_txd,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW  = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY < 0 || PARITY > 2 || DIV < 1 || OVERSAMPLE < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_param: invalid parameter combination");
  end

  logic [DW-1:0]        div_cnt_reg;
  logic                 br_tick;
  tx_state_t            state_reg, state_next;
  logic [TW-1:0]        tick_reg, tick_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] line_sel;
  logic                 txd_reg, txd_next;
  logic                 done_reg, done_next;
  logic                 bit_end;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (i_valid),
    .wr_data (i_data),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_fifo_count)
  );

  // Tick generator is never re-aligned to a frame; the start bit absorbs the slip.
  assign br_tick = (div_cnt_reg == DW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        div_cnt_reg <= '0;
    else if (br_tick) div_cnt_reg <= '0;
    else              div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  assign bit_end = br_tick && (tick_reg == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    fifo_pop   = 1'b0;
    done_next  = 1'b0;
    txd_next   = 1'b1;
    line_sel   = '0;

    if (state_reg != ST_IDLE && br_tick) begin
      tick_next = bit_end ? '0 : tick_reg + 1'b1;
    end

    // bit_reg indexes data bits in DATA and counts stop bits in STOP.
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_data;
          tick_next  = '0;
          bit_next   = '0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_reg == BW'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_reg == BW'(STOP_BITS - 1)) begin
            bit_next   = '0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Line value follows the state being entered, so TXD changes with the state.
    line_sel = shift_next >> bit_next;
    case (state_next)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = line_sel[0];
      ST_PARITY: txd_next = (PARITY == PAR_ODD) ? ~(^shift_next) : ^shift_next;
      default:   txd_next = 1'b1;
    endcase
  end

  assign o_ready = !fifo_full;
  assign o_txd   = txd_reg;
  assign o_busy  = (state_reg != ST_IDLE);
  assign o_done  = done_reg;

endmodule
